// File: rtl/usb_arb_pkg.sv
// usb_arb_pkg: shared definitions for the USB write-port arbiter family.
//   arb_state_e  - arbiter FSM states (IDLE, GRANT, RELEASE)
//   DEF_DW       - default write data width
//   DEF_FIFO_DEPTH - default USB FIFO depth in words
//   fifo_limit() - fill level at or above which a write is refused
package usb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_DW         = 32;
    localparam int DEF_FIFO_DEPTH = 1024;

    // Writes are accepted only while the fill level is strictly below this,
    // leaving one slot of slack for the word already in the output register.
    function automatic int fifo_limit(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/usb_wr_arbiter_if.sv
// usb_wr_arbiter_if: requester / FIFO side bundle of the USB write arbiter.
//   Apply[NREQ]        requester bus request (level)
//   ReqWrite[NREQ*DW]  requester write data, lane i at [i*DW +: DW]
//   ReqWreq[NREQ]      requester write strobe
//   Grant[NREQ]        one-hot grant
//   USBWrite[DW]       FIFO write data
//   USBWreq            FIFO write strobe
//   USBFIFOFul         FIFO full flag
//   NumFIFO            FIFO fill level
//   Busy, Ovf, TimeoutFlag  status
// modport master: requesters + FIFO model; modport slave: the arbiter.
interface usb_wr_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 1024
);
    localparam int CW = $clog2(FIFO_DEPTH);

    logic [NREQ-1:0]    Apply;
    logic [NREQ*DW-1:0] ReqWrite;
    logic [NREQ-1:0]    ReqWreq;
    logic [NREQ-1:0]    Grant;
    logic [DW-1:0]      USBWrite;
    logic               USBWreq;
    logic               USBFIFOFul;
    logic [CW-1:0]      NumFIFO;
    logic               Busy;
    logic               Ovf;
    logic               TimeoutFlag;

    modport master (
        output Apply, ReqWrite, ReqWreq, USBFIFOFul, NumFIFO,
        input  Grant, USBWrite, USBWreq, Busy, Ovf, TimeoutFlag
    );

    modport slave (
        input  Apply, ReqWrite, ReqWreq, USBFIFOFul, NumFIFO,
        output Grant, USBWrite, USBWreq, Busy, Ovf, TimeoutFlag
    );
endinterface

// File: rtl/usb_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req[N]    requests
//   ptr       highest-priority index; search runs ptr, ptr+1, ... wrapping at N-1
//   winner[N] one-hot winner (all zero when nothing requests)
//   valid     some request was found
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_wr_arbiter.sv
// usb_wr_arbiter: shares the single USB FIFO write port between NREQ requesters.
//   Clk  - system clock, rising edge
//   Rst  - asynchronous active-high reset
//   bus  - usb_wr_arbiter_if.slave (requests, grant, FIFO write port, status)
// A requester raises Apply, waits for its Grant bit, strobes words, then
// drops Apply. Each ownership ends with one dead RELEASE cycle.
// Optional macro ARB_TIMEOUT_EN: watchdog revokes a grant held for TIMEOUT
// cycles, sets sticky TimeoutFlag and masks that owner until its Apply drops.
// Without it TimeoutFlag is constant 0.
module usb_wr_arbiter
    import usb_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = 1023
) (
    input logic             Clk,
    input logic             Rst,
    usb_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] LIMIT = (CW+1)'(fifo_limit(FIFO_DEPTH));

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("usb_wr_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [DW-1:0]   usb_write_q, usb_write_d;
    logic            usb_wreq_q, usb_wreq_d;
    logic            ovf_q, ovf_d;

    logic [NREQ-1:0] req_elig;
    logic [NREQ-1:0] pick_oh;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [DW-1:0]   owner_wdata;
    logic            owner_wreq;
    logic            owner_apply;
    logic            room;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic            tmo_flag_q, tmo_flag_d;

    assign req_elig = bus.Apply & ~mask_q;
`else
    assign req_elig = bus.Apply;
`endif

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req    (req_elig),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    // Only the current owner's lane is ever looked at.
    assign owner_wdata = bus.ReqWrite[owner_q*DW +: DW];
    assign owner_wreq  = bus.ReqWreq[owner_q];
    assign owner_apply = bus.Apply[owner_q];
    assign room        = !bus.USBFIFOFul && ({1'b0, bus.NumFIFO} < LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        usb_write_d = usb_write_q;
        usb_wreq_d  = 1'b0;
        ovf_d       = ovf_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        mask_d      = mask_q & bus.Apply;   // a revoked owner is re-armed once it lets go
        tmo_flag_d  = tmo_flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                // Data is captured on the same edge that may end the grant,
                // so a strobe in the Apply-drop cycle is still forwarded.
                usb_write_d = owner_wdata;
                usb_wreq_d  = owner_wreq & room;
                if (owner_wreq && !room) ovf_d = 1'b1;
                if (!owner_apply) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT)) begin
                    grant_d         = '0;
                    state_d         = RELEASE;
                    tmo_flag_d      = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            usb_write_q <= '0;
            usb_wreq_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            usb_write_q <= usb_write_d;
            usb_wreq_q  <= usb_wreq_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tmo_cnt_q  <= '0;
            mask_q     <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            mask_q     <= mask_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign bus.TimeoutFlag = tmo_flag_q;
`else
    assign bus.TimeoutFlag = 1'b0;
`endif

    assign bus.Grant    = grant_q;
    assign bus.USBWrite = usb_write_q;
    assign bus.USBWreq  = usb_wreq_q;
    assign bus.Ovf      = ovf_q;
    assign bus.Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_wr_arbiter.sv
// Self-checking bench for usb_wr_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_usb_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    usb_wr_arbiter_if #(.NREQ(N), .DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    usb_wr_arbiter #(.NREQ(N), .DW(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lane i carries d ^ (i * 32'h11111111), so only the owner lane yields
    // the value the table expects.
    task automatic drive(input logic [3:0] ap, input logic [3:0] wq, input logic [31:0] d,
                         input logic ful, input logic [9:0] num);
        bus.Apply = ap;
        bus.ReqWreq = wq;
        for (int i = 0; i < N; i++) bus.ReqWrite[i*DW +: DW] = d ^ (32'h11111111 * i);
        bus.USBFIFOFul = ful;
        bus.NumFIFO = num;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        drive(4'b0, 4'b0, 32'h0, 1'b0, 10'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // FIFO-side monitor
    logic [31:0] got[$];
    bit mon_en = 1'b0;
    always @(negedge Clk) if (mon_en && bus.USBWreq === 1'b1) got.push_back(bus.USBWrite);

    typedef struct {
        logic [3:0]  ap;
        logic [3:0]  wq;
        logic [31:0] d;
        logic        ful;
        logic [9:0]  num;
        logic [3:0]  g;
        logic        wr;
        logic [31:0] w;
        logic        ovf;
        logic        busy;
    } vec_t;
    vec_t tv[12];

    // Behavioural reference model state
    int          m_owner;
    bit          m_rel;
    int          m_ptr;
    bit          m_ovf;
    logic [31:0] m_write;
    bit          e_wreq;

    task automatic model_reset();
        m_owner = -1; m_rel = 0; m_ptr = 0; m_ovf = 0; m_write = 0; e_wreq = 0;
    endtask

    // Advance the model over one clock edge given the inputs held before it.
    task automatic model_step(input logic [3:0] ap, input logic [3:0] wq, input logic [31:0] wd[N],
                              input bit ful, input int num);
        bit room;
        bit found;
        e_wreq = 0;
        if (m_owner >= 0) begin
            room = !ful && (num < DEPTH - 1);
            m_write = wd[m_owner];
            e_wreq = wq[m_owner] && room;
            if (wq[m_owner] && !room) m_ovf = 1;
            if (!ap[m_owner]) begin m_owner = -1; m_rel = 1; end
        end else if (m_rel) begin
            m_rel = 0;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && ap[j]) begin found = 1; m_owner = j; m_ptr = (j + 1) % N; end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0]  ap, wq;
        logic [31:0] wd[N];
        int          budget[N];
        int          age[N];
        bit          ful;
        int          num;
        int          gcnt, waited;
        bit          dropped, regrant;
        int          order[5];

        // ---------------- reset with all requests pending
        Rst = 1'b1;
        drive(4'b1111, 4'b0, 32'h0, 1'b0, 10'd0);
        repeat (2) @(negedge Clk);
        chk("rst_grant", bus.Grant, 4'b0);
        chk("rst_wreq", bus.USBWreq, 1'b0);
        chk("rst_write", bus.USBWrite, 32'h0);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_ovf", bus.Ovf, 1'b0);
        chk("rst_tflag", bus.TimeoutFlag, 1'b0);

        // ---------------- round robin, 2 words per owner
        Rst = 1'b0;
        got.delete();
        mon_en = 1'b1;
        order = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            waited = 0;
            while (bus.Grant == 4'b0 && waited < 8) begin @(negedge Clk); waited++; end
            chk($sformatf("rr_grant%0d", t), bus.Grant, 4'b1 << order[t]);
            if (t < 4) begin
                for (int w = 0; w < 2; w++) begin
                    drive(4'b1111, 4'b1 << order[t],
                          (32'hA000_0000 + t*2 + w) ^ (32'h11111111 * order[t]), 1'b0, 10'd0);
                    @(negedge Clk);
                end
                drive(4'b1111 & ~(4'b1 << order[t]), 4'b0, 32'h0, 1'b0, 10'd0);
                @(negedge Clk);
                drive(4'b1111, 4'b0, 32'h0, 1'b0, 10'd0);
            end
        end
        drive(4'b0, 4'b0, 32'h0, 1'b0, 10'd0);
        repeat (3) @(negedge Clk);
        mon_en = 1'b0;
        chk("rr_word_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("rr_word%0d", k), got[k], 32'hA000_0000 + k);

        // ---------------- directed vector table (starts from reset, pointer 0)
        tv[0]  = '{4'b0010, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0010, 1'b0, 32'h0, 1'b0, 1'b1};
        tv[1]  = '{4'b0010, 4'b0010, 32'h1, 1'b1, 10'd0,    4'b0010, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[2]  = '{4'b0010, 4'b0010, 32'h2, 1'b0, 10'd1023, 4'b0010, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[3]  = '{4'b0010, 4'b0010, 32'h12345678 ^ 32'h11111111, 1'b0, 10'd1022,
                   4'b0010, 1'b1, 32'h12345678, 1'b1, 1'b1};
        tv[4]  = '{4'b0010, 4'b1101, 32'h5, 1'b0, 10'd0,    4'b0010, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[5]  = '{4'b0000, 4'b0010, 32'hDEADBEEF ^ 32'h11111111, 1'b0, 10'd3,
                   4'b0000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1};
        tv[6]  = '{4'b0110, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0000, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[7]  = '{4'b0110, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0100, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[8]  = '{4'b0110, 4'b0110, 32'hCAFE0002 ^ 32'h22222222, 1'b0, 10'd5,
                   4'b0100, 1'b1, 32'hCAFE0002, 1'b1, 1'b1};
        tv[9]  = '{4'b0010, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0000, 1'b0, 32'h0, 1'b1, 1'b1};
        tv[10] = '{4'b0010, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0000, 1'b0, 32'h0, 1'b1, 1'b0};
        tv[11] = '{4'b0010, 4'b0000, 32'h0, 1'b0, 10'd0,    4'b0010, 1'b0, 32'h0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].ap, tv[i].wq, tv[i].d, tv[i].ful, tv[i].num);
            @(negedge Clk);
            chk($sformatf("vec%0d_grant", i), bus.Grant, tv[i].g);
            chk($sformatf("vec%0d_wreq", i), bus.USBWreq, tv[i].wr);
            if (tv[i].wr) chk($sformatf("vec%0d_write", i), bus.USBWrite, tv[i].w);
            chk($sformatf("vec%0d_ovf", i), bus.Ovf, tv[i].ovf);
            chk($sformatf("vec%0d_busy", i), bus.Busy, tv[i].busy);
        end

        // ---------------- reset in the middle of a transaction
        do_reset();
        drive(4'b0001, 4'b0, 32'h0, 1'b0, 10'd0);
        @(negedge Clk);
        chk("midrst_pre_grant", bus.Grant, 4'b0001);
        drive(4'b0001, 4'b0001, 32'h0BAD_0001, 1'b0, 10'd0);
        #2 Rst = 1'b1;
        #1;
        chk("midrst_grant", bus.Grant, 4'b0);
        chk("midrst_busy", bus.Busy, 1'b0);
        @(negedge Clk);
        chk("midrst_wreq", bus.USBWreq, 1'b0);
        Rst = 1'b0;

        // ---------------- long hold: watchdog (if built in) or indefinite grant
        do_reset();
        drive(4'b0001, 4'b0, 32'h0, 1'b0, 10'd0);
        gcnt = 0; dropped = 0; regrant = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (bus.Grant == 4'b0001) begin
                if (dropped) regrant = 1; else gcnt++;
            end else if (gcnt > 0) dropped = 1;
        end
`ifdef ARB_TIMEOUT_EN
        chk("hold_grant_cycles", gcnt, 17);
        chk("hold_tflag", bus.TimeoutFlag, 1'b1);
        chk("hold_no_regrant", regrant, 1'b0);
        drive(4'b0000, 4'b0, 32'h0, 1'b0, 10'd0);
        @(negedge Clk);
        drive(4'b0001, 4'b0, 32'h0, 1'b0, 10'd0);
        waited = 0;
        while (bus.Grant == 4'b0 && waited < 6) begin @(negedge Clk); waited++; end
        chk("hold_regrant_after_toggle", bus.Grant, 4'b0001);
`else
        chk("hold_grant_cycles", gcnt, 40);
        chk("hold_tflag", bus.TimeoutFlag, 1'b0);
`endif

        // ---------------- randomized run against the reference model
        do_reset();
        model_reset();
        ap = '0;
        for (int i = 0; i < N; i++) begin budget[i] = 0; age[i] = 0; wd[i] = '0; end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            wq = '0;
            for (int i = 0; i < N; i++) begin
                wd[i] = $urandom;
                if (!ap[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ap[i] = 1'b1; budget[i] = $urandom_range(0, 4); age[i] = 0;
                    end
                end else if (m_owner == i) begin
                    age[i]++;
                    if (budget[i] > 0 && $urandom_range(0, 9) < 7) begin
                        wq[i] = 1'b1; budget[i]--;
                    end
                    if (budget[i] == 0 || age[i] >= 8) ap[i] = 1'b0;
                end else begin
                    wq[i] = ($urandom_range(0, 7) == 0);
                end
            end
            ful = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0: num = 1023;
                1: num = 1022;
                default: num = $urandom_range(0, 1021);
            endcase
            bus.Apply = ap;
            bus.ReqWreq = wq;
            for (int i = 0; i < N; i++) bus.ReqWrite[i*DW +: DW] = wd[i];
            bus.USBFIFOFul = ful;
            bus.NumFIFO = 10'(num);
            @(negedge Clk);
            model_step(ap, wq, wd, ful, num);
            chk($sformatf("rnd%0d_grant", cyc), bus.Grant, (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0);
            chk($sformatf("rnd%0d_wreq", cyc), bus.USBWreq, e_wreq);
            if (e_wreq) chk($sformatf("rnd%0d_write", cyc), bus.USBWrite, m_write);
            chk($sformatf("rnd%0d_ovf", cyc), bus.Ovf, m_ovf);
            chk($sformatf("rnd%0d_busy", cyc), bus.Busy, (m_owner >= 0) || m_rel);
        end
        chk("rnd_tflag", bus.TimeoutFlag, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
